// File: rtl/rpn_stack_calc_p.sv
// rtl/rpn_stack_calc_p.sv - RPN stack calculator, top of stack in a register, rest in RAM
// Purpose : one command per valid/ready handshake; PUSH/NEG/ADD/SUB/DUP/DROP/SWAP
//           complete at the accepting edge, MUL runs a WIDTH-cycle shift-add.
// Ports   : clk, nrst (async active-low)
//           cmd_valid/cmd_ready handshake, cmd_push, cmd_op, cmd_data
//           err_clr clears the sticky error
//           top (top of stack), cnt (entries), err, err_code (01 overflow, 10 underflow)
module rpn_stack_calc_p #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 1024,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_push,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             err_clr,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    cnt,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_NEG  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_DUP  = 3'd5;
    localparam logic [2:0] OP_DROP = 3'd6;
    localparam logic [2:0] OP_SWAP = 3'd7;

    logic [WIDTH-1:0] mem [0:DEPTH-2];

    logic [WIDTH-1:0] top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    step_q, step_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    t_addr, s_addr;
    logic [WIDTH-1:0] s_val, acc_step;
    logic             has1, has2, full, set_ovf, set_unf;

    // T's spill slot is mem[cnt-1]; S lives one below it.
    assign t_addr   = AW'(cnt_q - CW'(1));
    assign s_addr   = AW'(cnt_q - CW'(2));
    assign s_val    = mem[s_addr];
    assign has1     = (cnt_q >= CW'(1));
    assign has2     = (cnt_q >= CW'(2));
    assign full     = (cnt_q == CW'(DEPTH));
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    assign cmd_ready = (state_q == ST_IDLE);
    assign top       = top_q;
    assign cnt       = cnt_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

    always_comb begin
        top_d    = top_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        wr_en    = 1'b0;
        wr_addr  = t_addr;
        wr_data  = top_q;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;

        if (state_q == ST_MUL) begin
            // Only the low WIDTH bits of the product are kept, so the
            // multiplicand can shift out of range without harm.
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            step_d   = step_q + SW'(1);
            if (step_q == SW'(WIDTH - 1)) begin
                top_d   = acc_step;
                cnt_d   = cnt_q - CW'(1);
                state_d = ST_IDLE;
            end
        end else if (cmd_valid) begin
            if (cmd_push) begin
                if (full) begin
                    set_ovf = 1'b1;
                end else begin
                    wr_en = has1;
                    top_d = cmd_data;
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                case (cmd_op)
                    OP_NEG: begin
                        if (!has1) set_unf = 1'b1;
                        else       top_d   = -top_q;
                    end
                    OP_ADD, OP_SUB: begin
                        if (!has2) begin
                            set_unf = 1'b1;
                        end else begin
                            top_d = (cmd_op == OP_ADD) ? (s_val + top_q) : (s_val - top_q);
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    OP_MUL: begin
                        if (!has2) begin
                            set_unf = 1'b1;
                        end else begin
                            mcand_d  = s_val;
                            mplier_d = top_q;
                            acc_d    = '0;
                            step_d   = '0;
                            state_d  = ST_MUL;
                        end
                    end
                    OP_DUP: begin
                        if (!has1) begin
                            set_unf = 1'b1;
                        end else if (full) begin
                            set_ovf = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    OP_DROP: begin
                        if (!has1) begin
                            set_unf = 1'b1;
                        end else begin
                            top_d = has2 ? s_val : '0;
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    OP_SWAP: begin
                        if (!has2) begin
                            set_unf = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            wr_addr = s_addr;
                            top_d   = s_val;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // A new error recorded on the same edge as err_clr takes priority.
        err_d      = err_q;
        err_code_d = err_code_q;
        if (err_clr) begin
            err_d      = 1'b0;
            err_code_d = 2'b00;
        end
        if (set_ovf) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
        end else if (set_unf) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            top_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            state_q    <= ST_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            step_q     <= '0;
        end else begin
            top_q      <= top_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
endmodule
